// File: rtl/pid_multi_channel.sv
// rtl/pid_multi_channel.sv - time-multiplexed multi-channel PID controller
// Optional derivative term (Kd bank, err_prev, KD divider) built when PID_DERIVATIVE_EN is defined.

module pid_multi_channel #(
    parameter int DATA_W    = 24,
    parameter int CHANNELS  = 4,
    parameter int FRAC_BITS = 0,
    parameter int KD_DIV    = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [CHANNELS*DATA_W-1:0] setpoint,
    input  logic [CHANNELS*DATA_W-1:0] state,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_ch,
    input  logic [2:0]                 cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic [CHANNELS-1:0]        int_clear,
    output logic [CHANNELS*DATA_W-1:0] duty,
    output logic [CHANNELS-1:0]        duty_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int PW   = 2*DATA_W + 2;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [DATA_W:0] ERR_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SUM, S_CLAMP, S_WRITE} fsm_t;

    fsm_t            fsm;
    logic [CH_W-1:0] ch;

    logic signed [DATA_W-1:0] kp_bank      [CHANNELS];
    logic signed [DATA_W-1:0] ki_bank      [CHANNELS];
    logic signed [DATA_W-1:0] pwm_lim_bank [CHANNELS];
    logic signed [DATA_W-1:0] int_lim_bank [CHANNELS];
    logic signed [DATA_W-1:0] db_bank      [CHANNELS];
    logic signed [DATA_W-1:0] integ_bank   [CHANNELS];

    logic signed [DATA_W-1:0] err_r, integ_r, kp_r, ki_r, pl_r, il_r, integ_next_r, res_r;
    logic signed [PW-1:0]     prod_p, prod_i, sum_r;

`ifdef PID_DERIVATIVE_EN
    localparam int KD_W = (KD_DIV > 1) ? $clog2(KD_DIV) : 1;
    localparam logic [KD_W-1:0] KD_LAST = KD_W'(KD_DIV - 1);

    logic signed [DATA_W-1:0] kd_bank       [CHANNELS];
    logic signed [DATA_W-1:0] err_prev_bank [CHANNELS];
    logic signed [DATA_W-1:0] kd_r, ep_r;
    logic signed [PW-1:0]     prod_d;
    logic [KD_W-1:0]          kd_cnt;
`endif

    logic signed [DATA_W-1:0] sp_sel, st_sel, err_sat, err_abs, err_load, integ_next;
    logic signed [DATA_W:0]   err_wide, integ_sum, il_x;

    // Error path for the channel in LOAD and the clamped integral for the channel in MUL.
    always_comb begin
        sp_sel   = setpoint[ch*DATA_W +: DATA_W];
        st_sel   = state[ch*DATA_W +: DATA_W];
        err_wide = (DATA_W+1)'(sp_sel) - (DATA_W+1)'(st_sel);
        if (err_wide > ERR_MAX)
            err_sat = DATA_W'(ERR_MAX);
        else if (err_wide < -ERR_MAX)
            err_sat = DATA_W'(-ERR_MAX);
        else
            err_sat = err_wide[DATA_W-1:0];
        err_abs  = err_sat[DATA_W-1] ? -err_sat : err_sat;
        err_load = (err_abs <= db_bank[ch]) ? '0 : err_sat;

        integ_sum = (DATA_W+1)'(integ_r) + (DATA_W+1)'(err_r);
        il_x      = (DATA_W+1)'(il_r);
        if (integ_sum > il_x)
            integ_next = il_r;
        else if (integ_sum < -il_x)
            integ_next = -il_r;
        else
            integ_next = integ_sum[DATA_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                kp_bank[k]      <= '0;
                ki_bank[k]      <= '0;
                pwm_lim_bank[k] <= '0;
                int_lim_bank[k] <= '0;
                db_bank[k]      <= '0;
                integ_bank[k]   <= '0;
`ifdef PID_DERIVATIVE_EN
                kd_bank[k]       <= '0;
                err_prev_bank[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (cfg_we && cfg_ch == 4'(k)) begin
                    case (cfg_addr)
                        3'd0: kp_bank[k]      <= cfg_data;
                        3'd1: ki_bank[k]      <= cfg_data;
`ifdef PID_DERIVATIVE_EN
                        3'd2: kd_bank[k]      <= cfg_data;
`endif
                        3'd3: pwm_lim_bank[k] <= cfg_data;
                        3'd4: int_lim_bank[k] <= cfg_data;
                        3'd5: db_bank[k]      <= cfg_data;
                        default: ;
                    endcase
                end
                // A clear on the channel being written wins over the write-back.
                if (int_clear[k]) begin
                    integ_bank[k] <= '0;
`ifdef PID_DERIVATIVE_EN
                    err_prev_bank[k] <= '0;
`endif
                end else if (fsm == S_WRITE && ch == CH_W'(k)) begin
                    integ_bank[k] <= integ_next_r;
`ifdef PID_DERIVATIVE_EN
                    if (kd_cnt == '0)
                        err_prev_bank[k] <= err_r;
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            fsm          <= S_IDLE;
            ch           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            duty_valid   <= '0;
            duty         <= '0;
            err_r        <= '0;
            integ_r      <= '0;
            kp_r         <= '0;
            ki_r         <= '0;
            pl_r         <= '0;
            il_r         <= '0;
            integ_next_r <= '0;
            res_r        <= '0;
            prod_p       <= '0;
            prod_i       <= '0;
            sum_r        <= '0;
`ifdef PID_DERIVATIVE_EN
            kd_r   <= '0;
            ep_r   <= '0;
            prod_d <= '0;
            kd_cnt <= '0;
`endif
        end else begin
            done       <= 1'b0;
            overrun    <= 1'b0;
            duty_valid <= '0;
            case (fsm)
                S_IDLE: begin
                    if (tick) begin
                        fsm <= S_LOAD;
                        ch  <= '0;
                    end
                end
                S_LOAD: begin
                    overrun <= tick;
                    busy    <= 1'b1;
                    err_r   <= err_load;
                    integ_r <= integ_bank[ch];
                    kp_r    <= kp_bank[ch];
                    ki_r    <= ki_bank[ch];
                    pl_r    <= pwm_lim_bank[ch][DATA_W-1] ? '0 : pwm_lim_bank[ch];
                    il_r    <= int_lim_bank[ch][DATA_W-1] ? '0 : int_lim_bank[ch];
`ifdef PID_DERIVATIVE_EN
                    kd_r <= kd_bank[ch];
                    ep_r <= err_prev_bank[ch];
`endif
                    fsm <= S_MUL;
                end
                S_MUL: begin
                    overrun      <= tick;
                    integ_next_r <= integ_next;
                    prod_p       <= PW'(kp_r) * PW'(err_r);
                    prod_i       <= PW'(ki_r) * PW'(integ_next);
`ifdef PID_DERIVATIVE_EN
                    prod_d <= PW'(kd_r) * PW'((DATA_W+1)'(err_r) - (DATA_W+1)'(ep_r));
`endif
                    fsm <= S_SUM;
                end
                S_SUM: begin
                    overrun <= tick;
`ifdef PID_DERIVATIVE_EN
                    sum_r <= (prod_p + prod_i + prod_d) >>> FRAC_BITS;
`else
                    sum_r <= (prod_p + prod_i) >>> FRAC_BITS;
`endif
                    fsm <= S_CLAMP;
                end
                S_CLAMP: begin
                    overrun <= tick;
                    if (sum_r > PW'(pl_r))
                        res_r <= pl_r;
                    else if (sum_r < -PW'(pl_r))
                        res_r <= -pl_r;
                    else
                        res_r <= sum_r[DATA_W-1:0];
                    fsm <= S_WRITE;
                end
                S_WRITE: begin
                    duty[ch*DATA_W +: DATA_W] <= res_r;
                    duty_valid[ch]            <= 1'b1;
                    if (ch == LAST_CH) begin
                        done <= 1'b1;
`ifdef PID_DERIVATIVE_EN
                        kd_cnt <= (kd_cnt == KD_LAST) ? '0 : kd_cnt + KD_W'(1);
`endif
                        // A tick on the closing edge starts the next scan back-to-back.
                        if (tick) begin
                            fsm <= S_LOAD;
                            ch  <= '0;
                        end else begin
                            fsm  <= S_IDLE;
                            busy <= 1'b0;
                        end
                    end else begin
                        overrun <= tick;
                        ch      <= ch + CH_W'(1);
                        fsm     <= S_LOAD;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_multi_channel.sv
// tb/tb_pid_multi_channel.sv - self-checking bench for pid_multi_channel
module tb_pid_multi_channel;

    localparam int DW  = 24;
    localparam int NC  = 4;
    localparam int FB  = 0;
    localparam int KDD = 1;
    localparam longint EMAX = (longint'(1) << (DW-1)) - 1;
`ifdef PID_DERIVATIVE_EN
    localparam bit DERIV = 1'b1;
`else
    localparam bit DERIV = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            reset = 1'b0;
    logic            tick = 1'b0;
    logic [NC*DW-1:0] setpoint = '0;
    logic [NC*DW-1:0] state = '0;
    logic            cfg_we = 1'b0;
    logic [3:0]      cfg_ch = '0;
    logic [2:0]      cfg_addr = '0;
    logic [DW-1:0]   cfg_data = '0;
    logic [NC-1:0]   int_clear = '0;
    logic [NC*DW-1:0] duty;
    logic [NC-1:0]   duty_valid;
    logic            busy, done, overrun;

    pid_multi_channel #(.DATA_W(DW), .CHANNELS(NC), .FRAC_BITS(FB), .KD_DIV(KDD)) dut (
        .CLK(CLK), .reset(reset), .tick(tick), .setpoint(setpoint), .state(state),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .int_clear(int_clear), .duty(duty), .duty_valid(duty_valid), .busy(busy),
        .done(done), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    longint m_kp[NC], m_ki[NC], m_kd[NC], m_pl[NC], m_il[NC], m_db[NC];
    longint m_int[NC], m_ep[NC], m_duty[NC];
    longint tb_sp[NC], tb_st[NC];
    int     m_scans;

    int   dv_cyc[NC];
    int   done_cyc, ov_cyc;
    logic busy_at1, busy_at_done;

    typedef struct {
        int kp; int ki; int pl; int il; int db; int sp; int st; longint exp;
    } vec_t;
    vec_t vt[13];

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic longint duty_of(input int k);
        logic signed [DW-1:0] v;
        v = duty[k*DW +: DW];
        return longint'(v);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_kp[k] = 0; m_ki[k] = 0; m_kd[k] = 0; m_pl[k] = 0; m_il[k] = 0; m_db[k] = 0;
            m_int[k] = 0; m_ep[k] = 0; m_duty[k] = 0;
        end
        m_scans = 0;
    endtask

    task automatic model_cfg(input int ch, input int addr, input longint data);
        if (ch < NC && addr <= 5 && !(addr == 2 && !DERIV)) begin
            case (addr)
                0: m_kp[ch] = data;
                1: m_ki[ch] = data;
                2: m_kd[ch] = data;
                3: m_pl[ch] = data;
                4: m_il[ch] = data;
                default: m_db[ch] = data;
            endcase
        end
    endtask

    // One full scan in plain arithmetic: error, deadband, anti-windup, PID sum, output limit.
    task automatic model_scan();
        longint err, il, pl, integ, s;
        for (int k = 0; k < NC; k++) begin
            err = clampv(tb_sp[k] - tb_st[k], -EMAX, EMAX);
            if ((err < 0 ? -err : err) <= m_db[k]) err = 0;
            il = (m_il[k] < 0) ? 0 : m_il[k];
            pl = (m_pl[k] < 0) ? 0 : m_pl[k];
            integ = clampv(m_int[k] + err, -il, il);
            s = m_kp[k] * err + m_ki[k] * integ;
            if (DERIV) s = s + m_kd[k] * (err - m_ep[k]);
            s = s >>> FB;
            m_duty[k] = clampv(s, -pl, pl);
            m_int[k] = integ;
            if (DERIV && (m_scans % KDD) == 0) m_ep[k] = err;
        end
        m_scans++;
    endtask

    task automatic cfg_write(input int ch, input int addr, input longint data);
        @(negedge CLK);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_addr = 3'(addr); cfg_data = data[DW-1:0];
        @(negedge CLK);
        cfg_we = 1'b0;
        model_cfg(ch, addr, data);
    endtask

    task automatic cfg_ch0(input int kp, input int ki, input int pl, input int il, input int db);
        cfg_write(0, 0, kp);
        cfg_write(0, 1, ki);
        cfg_write(0, 3, pl);
        cfg_write(0, 4, il);
        cfg_write(0, 5, db);
    endtask

    task automatic clear_int(input logic [NC-1:0] mask);
        @(negedge CLK);
        int_clear = mask;
        @(negedge CLK);
        int_clear = '0;
        for (int k = 0; k < NC; k++)
            if (mask[k]) begin m_int[k] = 0; m_ep[k] = 0; end
    endtask

    task automatic drive_inputs();
        longint t;
        for (int k = 0; k < NC; k++) begin
            t = tb_sp[k]; setpoint[k*DW +: DW] = t[DW-1:0];
            t = tb_st[k]; state[k*DW +: DW] = t[DW-1:0];
        end
    endtask

    // Tick once and watch a bounded window; extra_at > 0 re-ticks so it is sampled at edge t+extra_at.
    task automatic run_scan(input int extra_at);
        drive_inputs();
        for (int k = 0; k < NC; k++) dv_cyc[k] = -1;
        done_cyc = -1; ov_cyc = -1; busy_at1 = 1'bx; busy_at_done = 1'bx;
        @(negedge CLK); tick = 1'b1;
        @(negedge CLK); tick = 1'b0;
        for (int c = 1; c <= 5*NC + 4; c++) begin
            @(negedge CLK);
            for (int k = 0; k < NC; k++)
                if (duty_valid[k] && dv_cyc[k] < 0) dv_cyc[k] = c;
            if (done && done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
            if (overrun && ov_cyc < 0) ov_cyc = c;
            if (c == 1) busy_at1 = busy;
            tick = (extra_at > 0 && c == extra_at - 1);
        end
        tick = 1'b0;
        model_scan();
    endtask

    task automatic set_err0(input longint sp, input longint st);
        tb_sp[0] = sp; tb_st[0] = st;
    endtask

    initial begin
        int saw_done;
        int ch_r, addr_r, dat;
        logic [DW-1:0] r;

        vt[0]  = '{2, 0, 1000, 0, 0, 100, 90, 20};
        vt[1]  = '{1, 0, 50, 0, 0, 1000, 0, 50};
        vt[2]  = '{1, 0, 50, 0, 0, 0, 1000, -50};
        vt[3]  = '{1, 0, -5, 0, 0, 100, 0, 0};
        vt[4]  = '{1, 0, 8388607, 0, 0, 8388607, -8388608, 8388607};
        vt[5]  = '{1, 0, 8388607, 0, 0, -8388608, 8388607, -8388607};
        vt[6]  = '{1, 0, 1000, 0, 5, 5, 0, 0};
        vt[7]  = '{1, 0, 1000, 0, 5, 0, 5, 0};
        vt[8]  = '{1, 0, 1000, 0, 5, 0, 6, -6};
        vt[9]  = '{0, 1, 1000, 25, 0, 100, 0, 25};
        vt[10] = '{-3, 0, 1000, 0, 0, 7, 0, -21};
        vt[11] = '{3, 2, 1000, 1000, 0, -4, 0, -20};
        vt[12] = '{100, 0, 8388607, 0, 0, 8388607, -8388608, 8388607};

        for (int k = 0; k < NC; k++) begin tb_sp[k] = 0; tb_st[k] = 0; end
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        model_reset();

        for (int k = 0; k < NC; k++) chk($sformatf("reset_duty%0d", k), duty_of(k), 0);
        chk("reset_duty_valid", longint'(duty_valid), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_overrun", longint'(overrun), 0);

        for (int k = 0; k < NC; k++) begin tb_sp[k] = 500; tb_st[k] = 0; end
        run_scan(0);
        for (int k = 0; k < NC; k++) chk($sformatf("zero_gain_duty%0d", k), duty_of(k), 0);

        for (int k = 0; k < NC; k++) begin tb_sp[k] = 0; tb_st[k] = 0; end
        cfg_ch0(2, 0, 1000, 0, 0);
        set_err0(100, 90);
        run_scan(0);
        chk("timing_duty0", duty_of(0), 20);
        for (int k = 0; k < NC; k++) chk($sformatf("timing_dv%0d_cycle", k), dv_cyc[k], 5*(k+1));
        chk("timing_done_cycle", done_cyc, 5*NC);
        chk("timing_busy_after_load", longint'(busy_at1), 1);
        chk("timing_busy_at_done", longint'(busy_at_done), 0);

        for (int i = 0; i < 13; i++) begin
            cfg_ch0(vt[i].kp, vt[i].ki, vt[i].pl, vt[i].il, vt[i].db);
            clear_int(1);
            set_err0(vt[i].sp, vt[i].st);
            run_scan(0);
            chk($sformatf("vec%0d_duty0", i), duty_of(0), vt[i].exp);
        end

        cfg_ch0(0, 1, 1000, 25, 0);
        clear_int(1);
        set_err0(10, 0);
        run_scan(0); chk("integ_scan1", duty_of(0), 10);
        run_scan(0); chk("integ_scan2", duty_of(0), 20);
        run_scan(0); chk("integ_scan3_clamped", duty_of(0), 25);
        clear_int(1);
        run_scan(0); chk("integ_after_clear", duty_of(0), 10);

        cfg_ch0(1, 1, 1000, 1000, 0);
        clear_int(1);
        set_err0(7, 0);
        run_scan(0); chk("db_preload", duty_of(0), 14);
        cfg_write(0, 5, 5);
        set_err0(3, 0);
        run_scan(0); chk("db_inside", duty_of(0), 7);
        run_scan(0); chk("db_integ_held", duty_of(0), 7);

        cfg_ch0(2, 0, 1000, 0, 0);
        set_err0(100, 90);
        run_scan(3);
        chk("overrun_cycle", ov_cyc, 3);
        chk("overrun_dv0_cycle", dv_cyc[0], 5);
        chk("overrun_done_cycle", done_cyc, 5*NC);
        chk("overrun_duty0", duty_of(0), 20);

        cfg_ch0(0, 0, 1000, 0, 0);
        cfg_write(0, 2, 1);
        clear_int(1);
        set_err0(0, 0);
        run_scan(0); chk("deriv_scan1", duty_of(0), 0);
        set_err0(40, 0);
        run_scan(0); chk("deriv_step", duty_of(0), DERIV ? 40 : 0);
        run_scan(0); chk("deriv_hold", duty_of(0), 0);

        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 3; w++) begin
                ch_r = $urandom_range(0, 5);
                addr_r = $urandom_range(0, 7);
                case (addr_r)
                    3: dat = $urandom_range(0, 6000) - 500;
                    4: dat = $urandom_range(0, 3000) - 100;
                    5: dat = $urandom_range(0, 60) - 5;
                    default: dat = $urandom_range(0, 16) - 8;
                endcase
                cfg_write(ch_r, addr_r, dat);
            end
            if ($urandom_range(0, 3) == 0) clear_int(NC'($urandom));
            for (int k = 0; k < NC; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    r = DW'($urandom); tb_sp[k] = longint'($signed(r));
                    r = DW'($urandom); tb_st[k] = longint'($signed(r));
                end else begin
                    dat = $urandom_range(0, 4000) - 2000; tb_sp[k] = dat;
                    dat = $urandom_range(0, 4000) - 2000; tb_st[k] = dat;
                end
            end
            run_scan(0);
            for (int k = 0; k < NC; k++)
                chk($sformatf("rand%0d_duty%0d", it, k), duty_of(k), m_duty[k]);
        end

        cfg_ch0(2, 0, 1000, 0, 0);
        set_err0(100, 90);
        drive_inputs();
        @(negedge CLK); tick = 1'b1;
        @(negedge CLK); tick = 1'b0;
        repeat (6) @(negedge CLK);
        model_scan();
        chk("pre_reset_duty0", duty_of(0), m_duty[0]);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < NC; k++) chk($sformatf("abort_duty%0d", k), duty_of(k), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_duty_valid", longint'(duty_valid), 0);
        saw_done = 0;
        repeat (25) begin
            @(negedge CLK);
            if (done) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);

        for (int k = 0; k < NC; k++) begin tb_sp[k] = 300; tb_st[k] = 0; end
        run_scan(0);
        for (int k = 0; k < NC; k++) chk($sformatf("post_reset_duty%0d", k), duty_of(k), m_duty[k]);
        chk("post_reset_done_cycle", done_cyc, 5*NC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_multi_channel.md
# pid_multi_channel

Time-multiplexed, parametrised PID controller serving `CHANNELS` motor channels from a single multiplier datapath. It is the successor to the single-channel controller on the motor board. It adds:
- per-channel gain/limit register banks;
- a derivative term with a sample divider;
- deadband;
- integral anti-windup clamping;
- an explicit tick/scan handshake.

It sits between the encoder/state capture logic and the PWM generators.

## Interface
Parameters:
- `DATA_W`, 24: width of setpoints, states, gains, limits, duty.
- `CHANNELS`, 4: number of controlled channels (1..16).
- `FRAC_BITS`, 0: fixed-point fraction bits of gains; the sum is arithmetically shifted right by this amount.
- `KD_DIV`, 16: scans between err_prev snapshots (≥1).

Ports:
- `CLK`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `tick`  in  1  start one scan over all channels.
- `setpoint`  in  CHANNELS*DATA_W  packed signed setpoints; channel k is at [k*DATA_W +: DATA_W].
- `state`  in  CHANNELS*DATA_W  packed signed measured states.
- `cfg_we`  in  1  config write strobe.
- `cfg_ch`  in  4  config channel index.
- `cfg_addr`  in  3  register select: 0 Kp, 1 Ki, 2 Kd, 3 PWMLimit, 4 IntegralLimit, 5 deadband.
- `cfg_data`  in  DATA_W  signed write data.
- `int_clear`  in  CHANNELS  per-channel integral/err_prev clear.
- `duty`  out  CHANNELS*DATA_W  packed signed duty outputs, registered.
- `duty_valid`  out  CHANNELS  one-cycle pulse when channel k's duty is updated.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the last channel is written.
- `overrun`  out  1  one-cycle pulse when `tick` arrives while busy.

## Operation
- Reset (`reset`=0 at a CLK edge) clears the following to 0: all duty, integrals, err_prev, config registers, scan state, KD counter, and all outputs. With zero gains, duty stays 0 until configured.
- The FSM has six states: IDLE → LOAD → MUL → SUM → CLAMP → WRITE. WRITE → LOAD for the next channel; WRITE → IDLE after channel CHANNELS-1.
- `tick` in IDLE starts a scan at channel 0.
- `tick` while busy is ignored and pulses `overrun`.
- LOAD:
  - err = setpoint[ch] − state[ch], computed at DATA_W+1 bits and saturated to ±(2^(DATA_W-1)−1).
  - If |err| ≤ deadband, err is forced to 0.
- MUL: integral_next = integral + err, clamped to [−IntegralLimit, +IntegralLimit]. Products Kp*err, Ki*integral_next, and Kd*(err−err_prev) are computed at 2*DATA_W+2 bits.
- SUM: all products are summed, then arithmetically shifted right by FRAC_BITS.
- CLAMP: the result is saturated to [−PWMLimit, +PWMLimit]. A negative PWMLimit is treated as 0.
- WRITE:
  - duty[ch] and integral[ch] are updated and `duty_valid[ch]` pulses.
  - err_prev[ch] ← err only on scans where the KD counter is 0.
- The KD counter increments once per completed scan and wraps at KD_DIV−1.
- Config writes take effect immediately in the bank. A write to the channel currently in MUL..WRITE affects that channel from its next scan. The channel's operands are latched in LOAD.
- `int_clear[k]` zeroes integral[k] and err_prev[k] in the same cycle and takes priority over a WRITE to channel k in that cycle. The duty is untouched.
- `cfg_ch` ≥ CHANNELS and `cfg_addr` > 5: the write is ignored.

## Timing
- `tick` sampled at edge t: `busy`=1 from t+1; channel k's duty and `duty_valid[k]` change at edge t+5(k+1).
- `done` pulses at edge t+5*CHANNELS, with `busy`=0 at the same edge.
- A new `tick` is accepted at edge t+5*CHANNELS or later.
- Setpoint/state are sampled only in channel k's LOAD cycle.
- `reset` low mid-scan aborts the scan. All outputs are 0 after that edge; no `done` is produced.

## Configuration
- `PID_DERIVATIVE_EN` defined: the Kd register, the err_prev storage, the KD counter and the derivative product are built.
- `PID_DERIVATIVE_EN` undefined: the D term is constant 0 and the Kd register is absent. Writes to addr 2 are ignored and err_prev logic is removed. Scan timing is unchanged.

## Test plan
- Kp=2, Ki=0, PWMLimit=1000, FRAC_BITS=0; ch0 setpoint 100, state 90; tick → duty[0]=20 with `duty_valid[0]` exactly 5 cycles after tick, and `done` after 5*CHANNELS cycles.
- Kp=1, PWMLimit=50; err=+1000 → duty=50; err=−1000 → duty=−50.
- Ki=1, Kp=0, IntegralLimit=25, err=10; three ticks → duty 10, 20, 25. Then pulse `int_clear[0]` and tick → duty 10.
- deadband=5, Kp=1, Ki=1, integral preloaded to 7 via prior scans; err=3 → duty=7 and the integral is unchanged.
- Tick issued 3 cycles after a previous tick → `overrun` pulses, scan timing is unaffected. `reset`=0 during channel 1's MUL → all duty 0, busy 0, no `done`.
- With `PID_DERIVATIVE_EN`, Kd=1, KD_DIV=1, Kp=Ki=0; err 0 then 40 → duty 0 then 40, then 0 on the next scan with err held at 40.
